// File: rtl/abacus_pkg.sv
// Shared ABACUS profiler definitions: reader FSM states, register map offsets
// and the word-address helper used by the Wishbone counter reader.
package abacus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } abacus_reader_state_t;

  localparam logic [31:0] ABACUS_WORD_STRIDE        = 32'd4;
  localparam logic [15:0] ABACUS_INSTR_CNT_BASE_OFS = 16'h0100;
  localparam logic [15:0] ABACUS_CACHE_CNT_BASE_OFS = 16'h0200;

  // 9 bits so a 256-word window needs no wrap special case.
  localparam int unsigned ABACUS_INDEX_W = 9;

  // Byte address of counter word 'index' in a window starting at 'base'
  // (wraps modulo 2^32).
  function automatic logic [31:0] abacus_word_addr(input logic [31:0]               base,
                                                   input logic [ABACUS_INDEX_W-1:0] index);
    return base + (32'(index) * ABACUS_WORD_STRIDE);
  endfunction

endpackage

// File: rtl/abacus_ack_watchdog.sv
// Clear/count/expired counter that bounds how long the reader waits for a
// Wishbone acknowledge. Only instantiated when ABACUS_READER_TIMEOUT_EN is set.
module abacus_ack_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt;

  // Count wait cycles; saturate at the limit, restart whenever cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

  // Fires during the LIMIT-th counted cycle.
  assign expired = count && (cnt == LAST);

endmodule

// File: rtl/abacus_wb_reader.sv
// Wishbone classic read initiator: one 'start' sweeps NUM_WORDS counter
// registers from BASE_ADDR and streams each word out on a valid/ready port.
// Optional ack timeout guarded by the ABACUS_READER_TIMEOUT_EN macro.
//
// Sample handshake: smp_valid is held high with smp_data/smp_index stable
// until a cycle where smp_valid & smp_ready are both high; that edge is the
// transfer. smp_valid never drops without a transfer (except on reset).
module abacus_wb_reader
  import abacus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hf0030100,
  parameter int unsigned NUM_WORDS      = 11,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [31:0] smp_data,
  output logic [7:0]  smp_index,
  output logic [1:0]  dbg_state
);

  localparam logic [ABACUS_INDEX_W-1:0] LAST_IDX = ABACUS_INDEX_W'(NUM_WORDS - 1);

  // Elaboration-time parameter legality checks.
  if (NUM_WORDS < 1 || NUM_WORDS > 256) begin : g_bad_num_words
    $error("abacus_wb_reader: NUM_WORDS must be 1..256");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base_addr
    $error("abacus_wb_reader: BASE_ADDR must be 4-byte aligned");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("abacus_wb_reader: TIMEOUT_CYCLES must be 2..65535");
  end

  abacus_reader_state_t      state, state_next;
  logic [ABACUS_INDEX_W-1:0] idx_q;
  logic [31:0]               smp_data_q;
  logic [7:0]                smp_index_q;
  logic                      done_q;
  logic                      timeout_fire;
  logic                      accept_start;
  logic                      ack_take;
  logic                      transfer;
  logic                      last_word;

  assign accept_start = (state == IDLE) && start;
  assign ack_take     = (state == REQ) && wb_ack;
  assign transfer     = (state == HOLD) && smp_ready;
  assign last_word    = (idx_q == LAST_IDX);

`ifdef ABACUS_READER_TIMEOUT_EN
  logic wd_expired;
  logic err_q;

  abacus_ack_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_ack_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != REQ),
    .count  (state == REQ),
    .expired(wd_expired)
  );

  // An ack arriving in the expiry cycle still wins.
  assign timeout_fire = wd_expired && !wb_ack;

  // Sticky timeout flag, cleared when the next sweep is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept_start) begin
      err_q <= 1'b0;
    end else if (timeout_fire) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_fire = 1'b0;
  assign err          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: request, hold the sample, then advance or finish.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        if (wb_ack)            state_next = HOLD;
        else if (timeout_fire) state_next = IDLE;
      end
      HOLD: begin
        if (smp_ready) state_next = last_word ? IDLE : REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word index, captured sample and the end-of-sweep pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      smp_data_q  <= '0;
      smp_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (transfer && last_word) || timeout_fire;
      if (accept_start) begin
        idx_q <= '0;
      end else if (transfer && !last_word) begin
        idx_q <= idx_q + 1'b1;
      end
      if (ack_take) begin
        smp_data_q  <= wb_dat_i;
        smp_index_q <= idx_q[7:0];
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign wb_cyc    = (state == REQ);
  assign wb_stb    = (state == REQ);
  assign wb_we     = 1'b0;
  assign wb_dat_o  = '0;
  assign wb_adr    = (state == REQ) ? abacus_word_addr(BASE_ADDR, idx_q) : '0;
  assign smp_valid = (state == HOLD);
  assign smp_data  = smp_data_q;
  assign smp_index = smp_index_q;
  assign dbg_state = state;

endmodule

// File: doc/abacus_wb_reader.md
# abacus_wb_reader

Wishbone classic read initiator that walks a contiguous window of ABACUS profiler counter registers and streams each sampled word out on a valid/ready interface. It sits between the profiler's Wishbone register slave and an on-chip consumer (trace buffer, UART dumper) so counters are harvested without CPU load/store traffic. One `start` pulse triggers one sweep of `NUM_WORDS` reads.

## Interface
- `BASE_ADDR`, default `32'hf0030100`: byte address of word 0; must be 4-byte aligned.
- `NUM_WORDS`, default `11`: words per sweep; legal range is 1..256.
- `TIMEOUT_CYCLES`, default `16`: ack wait limit in cycles; only used with `ABACUS_READER_TIMEOUT_EN`; legal range is 2..65535.
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: single-cycle sweep request; ignored while `busy`.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse when a sweep ends, whether it completes or aborts.
- `err`, output, 1: sticky flag for an ack timeout; cleared by the next accepted `start`.
- `wb_cyc`, `wb_stb`, output, 1 each: the bus request; the two are always driven identically.
- `wb_we`, output, 1: tied to 0.
- `wb_adr`, output, 32: read address.
- `wb_dat_o`, output, 32: tied to 0.
- `wb_dat_i`, input, 32: read data; valid in any cycle where `wb_ack` is high.
- `wb_ack`, input, 1: responder acknowledge.
- `smp_valid`, output, 1: a sample is presented.
- `smp_ready`, input, 1: the consumer accepts the sample.
- `smp_data`, output, 32: captured `wb_dat_i`.
- `smp_index`, output, 8: word index (0..NUM_WORDS-1) of the presented sample.

## Operation
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - `start` → load index 0; next state REQ.
  - Clears `err` in the same edge.
- REQ:
  - `wb_cyc`/`wb_stb` high; `wb_adr = BASE_ADDR + 4*index`, computed modulo 2^32.
  - On a cycle with `wb_ack` high: capture `wb_dat_i` into `smp_data` and index into `smp_index`; next state HOLD.
- HOLD:
  - `wb_cyc`/`wb_stb` low; `smp_valid` high.
  - `smp_data` and `smp_index` stay stable until the transfer (`smp_valid & smp_ready`).
  - On transfer, if `index == NUM_WORDS-1`: pulse `done`; next state IDLE.
  - On transfer otherwise: increment index; next state REQ.
- `wb_ack` seen outside REQ is ignored; no data is captured.
- `start` in REQ or HOLD is dropped, not queued.
- Index counter is 9 bits internally, so `NUM_WORDS = 256` needs no wrap special case.
- Reset values:
  - All outputs 0.
  - `wb_adr` 0, `smp_data` 0, `smp_index` 0.
  - State IDLE.
- Reset asserted mid-sweep: all outputs drop immediately, asynchronously; the bus cycle is abandoned with no `done`.

## Timing
- `start` sampled at edge E0 → `wb_stb` high in cycle 1.
- With a registered responder, `wb_ack` rises in cycle 2 and data is captured at the end of cycle 2.
- `smp_valid` is high in cycle 3 with `wb_stb` already low. This gap satisfies the responder's `~wb_ack` single-ack rule.
- With `smp_ready` held high, the next `wb_stb` rises in cycle 4. Steady state is 3 cycles per word.
- `done` is high in the cycle after the final transfer edge; `busy` falls in that same cycle.
- `start` arriving in the `done` cycle is accepted, since state is IDLE.

## Configuration
- `ABACUS_READER_TIMEOUT_EN` defined:
  - A wait counter runs in REQ and resets on entry to REQ.
  - If it reaches `TIMEOUT_CYCLES` with no ack: `wb_cyc`/`wb_stb` drop next cycle, `err` is set, `done` pulses, and the remaining words are skipped.
  - No `smp_valid` is produced for the timed-out word.
- Macro not defined:
  - REQ waits indefinitely for `wb_ack`.
  - `err` is tied to 0; `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `abacus_pkg` holds:
  - the `abacus_reader_state_t` enum (IDLE, REQ, HOLD);
  - `ABACUS_WORD_STRIDE = 4`;
  - `ABACUS_INSTR_CNT_BASE_OFS = 16'h0100`;
  - `ABACUS_CACHE_CNT_BASE_OFS = 16'h0200`.
- One sub-module, `abacus_ack_watchdog`:
  - a clear/count/expired counter;
  - instantiated only under `ABACUS_READER_TIMEOUT_EN`.

## Test plan
- Default parameters; responder acks 1 cycle after `stb`; counter words `32'h100..32'h10A`; `smp_ready` high → addresses `f0030100..f0030128` in order; `smp_index` 0..10 with matching data; one `done`; `err = 0`; total 34 cycles from `start` to `done`.
- `smp_ready` low for 5 cycles while word 2 is presented → `smp_data` and `smp_index` hold; no new `wb_stb` until the transfer; no word lost or duplicated.
- `start` pulsed again in REQ of word 4 → ignored; exactly 11 samples and one `done`.
- `ABACUS_READER_TIMEOUT_EN`, `TIMEOUT_CYCLES = 16`, responder never acks word 3 → `wb_stb` drops after 16 REQ cycles; `err = 1`; `done` pulses; only indices 0..2 are emitted.
  - A following `start` with acks restored → `err` clears and the full sweep completes.
- `rst` asserted in HOLD of word 5 → all outputs 0 immediately; after release, IDLE with no `done`; a new sweep starts at index 0.
- `NUM_WORDS = 1`, `BASE_ADDR = 32'hfffffffc` → a single read at `fffffffc`; `done` follows its transfer.
